cu_fsm: RTL and testbench

- Multi-cycle control unit for the 8-bit MIPS Data Unit.
- Decodes the 12-bit instruction and steps a FETCH/DECODE/EXEC/MEM/WB state machine.
- Drives every DU control input: opALU, selB, selAddrMI, selAw, selD, wR.
- Also drives the instruction-register load and the data-memory strobes, and waits on a memory-ready handshake.

---
 rtl/cu_pkg.sv | 49 ++++
 rtl/cu_decode.sv | 58 +++++
 rtl/cu_fsm.sv | 136 +++++++++++++
 tb/tb_cu_fsm.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared types and encodings for the MIPS-8 multi-cycle control unit
package cu_pkg;
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_HALT
  } state_e;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_J    = 4'hD;
  localparam logic [3:0] OP_BCS  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_SHL = 5'd6;
  localparam logic [4:0] ALU_SHR = 5'd7;
  localparam logic [1:0] SELB_REG  = 2'd0;
  localparam logic [1:0] SELB_IMM  = 2'd1;
  localparam logic [1:0] SELB_ZERO = 2'd2;
  localparam logic [1:0] PC_HOLD   = 2'd0;
  localparam logic [1:0] PC_INC    = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_STATE   = 2'd2;
  typedef struct packed {
    logic [4:0] alu_op;
    logic [1:0] sel_b;
    logic       is_mem;
    logic       is_load;
    logic       is_branch;
    logic       sel_d;
    logic       sel_aw;
    logic       taken;
  } ctrl_t;
endpackage

// File: rtl/cu_decode.sv
// cu_decode: opcode to control-word table, including branch resolution on captured flags
module cu_decode
  import cu_pkg::*;
(
  input  logic [3:0] opc_i,
  input  logic       co_i,
  input  logic       z_i,
  output ctrl_t      ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (opc_i)
      OP_SUB: ctrl_o.alu_op = ALU_SUB;
      OP_AND: ctrl_o.alu_op = ALU_AND;
      OP_OR:  ctrl_o.alu_op = ALU_OR;
      OP_XOR: ctrl_o.alu_op = ALU_XOR;
      OP_ADDI: begin
        ctrl_o.sel_b  = SELB_IMM;
        ctrl_o.sel_aw = 1'b1;
      end
      OP_SHL: begin
        ctrl_o.alu_op = ALU_SHL;
        ctrl_o.sel_b  = SELB_IMM;
      end
      OP_SHR: begin
        ctrl_o.alu_op = ALU_SHR;
        ctrl_o.sel_b  = SELB_IMM;
      end
      OP_LW: begin
        ctrl_o.sel_b   = SELB_IMM;
        ctrl_o.is_mem  = 1'b1;
        ctrl_o.is_load = 1'b1;
        ctrl_o.sel_d   = 1'b1;
        ctrl_o.sel_aw  = 1'b1;
      end
      OP_SW: begin
        ctrl_o.sel_b  = SELB_IMM;
        ctrl_o.is_mem = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.is_branch = 1'b1;
        ctrl_o.taken     = z_i;
      end
      OP_BNE: begin
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.is_branch = 1'b1;
        ctrl_o.taken     = !z_i;
      end
      OP_BCS: begin
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.is_branch = 1'b1;
        ctrl_o.taken     = co_i;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/cu_fsm.sv
// cu_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the 8-bit MIPS data unit
module cu_fsm
  import cu_pkg::*;
#(
  parameter int ALU_OP_W    = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [11:0]         instruction,
  input  logic                co,
  input  logic                ov,
  input  logic                z,
  input  logic                coMI,
  input  logic                memReady,
  output logic [ALU_OP_W-1:0] opALU,
  output logic [1:0]          selB,
  output logic [1:0]          selAddrMI,
  output logic                selAw,
  output logic                selD,
  output logic                wR,
  output logic                irWe,
  output logic                memRe,
  output logic                memWe,
  output logic                halted,
  output logic [1:0]          err,
  output logic                pcWrap
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_e      state_q;
  logic [3:0]  opc_q;
  logic [CW-1:0] cnt_q;
  logic        co_q, ov_q, z_q, wrap_q;
  logic [1:0]  err_q;
  logic [3:0]  op_live;
  ctrl_t       ctrl;
  logic        unused_bits;
  assign op_live     = instruction[11:8];
  assign unused_bits = ^{instruction[7:0], ov_q};
  cu_decode u_decode (
    .opc_i  (opc_q),
    .co_i   (co_q),
    .z_i    (z_q),
    .ctrl_o (ctrl)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      opc_q   <= OP_NOP;
      cnt_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= ERR_NONE;
      wrap_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          wrap_q  <= wrap_q | coMI;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          opc_q   <= op_live;
          state_q <= op_live == OP_HALT ? S_HALT :
                     (op_live == OP_NOP || op_live == OP_J) ? S_FETCH : S_EXEC;
        end
        S_EXEC: begin
          co_q    <= co;
          ov_q    <= ov;
          z_q     <= z;
          cnt_q   <= '0;
          state_q <= ctrl.is_mem ? S_MEM : ctrl.is_branch ? S_BR : S_WB;
        end
        S_MEM: begin
          if (memReady) state_q <= ctrl.is_load ? S_WB : S_FETCH;
          else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
            err_q   <= ERR_TIMEOUT;
            state_q <= S_HALT;
          end else cnt_q <= cnt_q + CW'(1);
        end
        S_WB, S_BR: state_q <= S_FETCH;
        S_HALT: ;
        default: begin
          err_q   <= ERR_STATE;
          state_q <= S_HALT;
        end
      endcase
    end
  end
  // ALU controls stay asserted through MEM and WB so the address and result hold
  logic [4:0] op_alu;
  always_comb begin
    op_alu    = ALU_ADD;
    selB      = SELB_REG;
    selAddrMI = PC_HOLD;
    selAw     = 1'b0;
    selD      = 1'b0;
    wR        = 1'b0;
    irWe      = 1'b0;
    memRe     = 1'b0;
    memWe     = 1'b0;
    halted    = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          irWe      = 1'b1;
          selAddrMI = PC_INC;
        end
        S_DECODE: selAddrMI = op_live == OP_J ? PC_JUMP : PC_HOLD;
        S_EXEC: begin
          op_alu = ctrl.alu_op;
          selB   = ctrl.sel_b;
        end
        S_MEM: begin
          op_alu = ctrl.alu_op;
          selB   = ctrl.sel_b;
          memRe  = ctrl.is_load;
          memWe  = !ctrl.is_load;
        end
        S_WB: begin
          op_alu = ctrl.alu_op;
          selB   = ctrl.sel_b;
          wR     = 1'b1;
          selD   = ctrl.sel_d;
          selAw  = ctrl.sel_aw;
        end
        S_BR: selAddrMI = ctrl.taken ? PC_BRANCH : PC_HOLD;
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end
  assign opALU  = ALU_OP_W'(op_alu);
  assign err    = err_q;
  assign pcWrap = wrap_q;
endmodule

// File: tb/tb_cu_fsm.sv
// tb_cu_fsm: directed self-checking bench for the cu_fsm control unit
module tb_cu_fsm;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] instruction;
  logic        co, ov, z, coMI, memReady;
  logic [4:0]  opALU;
  logic [1:0]  selB, selAddrMI, err;
  logic        selAw, selD, wR, irWe, memRe, memWe, halted, pcWrap;
  int          n_tests = 0;
  int          n_fail  = 0;

  cu_fsm #(.ALU_OP_W(5), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .co(co), .ov(ov), .z(z),
    .coMI(coMI), .memReady(memReady), .opALU(opALU), .selB(selB),
    .selAddrMI(selAddrMI), .selAw(selAw), .selD(selD), .wR(wR), .irWe(irWe),
    .memRe(memRe), .memWe(memWe), .halted(halted), .err(err), .pcWrap(pcWrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
    #1;
  endtask

  task automatic branch(input logic [11:0] ins, input logic c, input logic zz,
                        input logic [1:0] exp, input string tag);
    instruction = ins;
    nxt;
    nxt;
    check({tag, "_alu"}, opALU, 1);
    check({tag, "_selb"}, selB, 0);
    co = c;
    z  = zz;
    nxt;
    co = ~c;
    z  = ~zz;
    #1;
    check({tag, "_pc"}, selAddrMI, exp);
    check({tag, "_wr"}, wR, 0);
    nxt;
    check({tag, "_fetch"}, irWe, 1);
    co = 1'b0;
    z  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; instruction = 12'h100;
    co = 1'b0; ov = 1'b0; z = 1'b0; coMI = 1'b0; memReady = 1'b0;
    nxt;
    check("rst_irwe", irWe, 0);
    check("rst_wr", wR, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);
    check("rst_wrap", pcWrap, 0);
    check("rst_alu", opALU, 0);
    rst = 1'b1;
    #1;
    check("add_c0_irwe", irWe, 1);
    check("add_c0_pc", selAddrMI, 1);
    nxt;
    check("add_c1_irwe", irWe, 0);
    nxt;
    check("add_exec_alu", opALU, 0);
    check("add_exec_selb", selB, 0);
    check("add_exec_wr", wR, 0);
    nxt;
    check("add_wb_wr", wR, 1);
    check("add_wb_seld", selD, 0);
    check("add_wb_selaw", selAw, 0);
    nxt;
    check("add_c4_fetch", irWe, 1);
    check("add_c4_wr", wR, 0);
    instruction = 12'h912;
    nxt;
    nxt;
    check("lw_exec_alu", opALU, 0);
    check("lw_exec_selb", selB, 1);
    for (int i = 0; i < 4; i++) begin
      nxt;
      check("lw_memre", memRe, 1);
      memReady = (i == 3);
    end
    nxt;
    memReady = 1'b0;
    check("lw_wb_wr", wR, 1);
    check("lw_wb_seld", selD, 1);
    check("lw_wb_selaw", selAw, 1);
    check("lw_wb_memre", memRe, 0);
    nxt;
    check("lw_fetch", irWe, 1);
    branch(12'hB00, 1'b0, 1'b1, 2'd3, "beq_t");
    branch(12'hB00, 1'b0, 1'b0, 2'd0, "beq_n");
    branch(12'hE00, 1'b1, 1'b0, 2'd3, "bcs_t");
    branch(12'hC00, 1'b0, 1'b1, 2'd0, "bne_n");
    instruction = 12'hD40;
    nxt;
    check("j_decode_pc", selAddrMI, 2);
    nxt;
    check("j_fetch_irwe", irWe, 1);
    check("j_fetch_pc", selAddrMI, 1);
    instruction = 12'h1AB;
    nxt;
    nxt;
    nxt;
    check("rwb_wr_before", wR, 1);
    rst = 1'b0;
    #1;
    check("rwb_wr_gated", wR, 0);
    nxt;
    check("rwb_idle_irwe", irWe, 0);
    check("rwb_idle_wr", wR, 0);
    check("rwb_idle_pc", selAddrMI, 0);
    check("rwb_idle_alu", opALU, 0);
    rst = 1'b1;
    #1;
    check("rwb_fetch", irWe, 1);
    instruction = 12'h000;
    coMI = 1'b1;
    nxt;
    coMI = 1'b0;
    check("wrap_set", pcWrap, 1);
    nxt;
    check("wrap_continue", irWe, 1);
    instruction = 12'hA00;
    nxt;
    nxt;
    for (int i = 0; i < 15; i++) begin
      nxt;
      check("sw_memwe", memWe, 1);
      check("sw_err_wait", err, 0);
    end
    nxt;
    check("sw_to_memwe", memWe, 0);
    check("sw_to_err", err, 1);
    check("sw_to_halted", halted, 1);
    check("sw_to_wrap", pcWrap, 1);
    rst = 1'b0;
    nxt;
    check("clr_err", err, 0);
    check("clr_halted", halted, 0);
    check("clr_wrap", pcWrap, 0);
    rst = 1'b1;
    instruction = 12'hF00;
    nxt;
    nxt;
    instruction = 12'h100;
    for (int i = 0; i < 4; i++) begin
      check("halt_halted", halted, 1);
      check("halt_irwe", irWe, 0);
      nxt;
    end
    rst = 1'b0;
    nxt;
    check("halt_rst", halted, 0);
    rst = 1'b1;
    #1;
    check("halt_rst_fetch", irWe, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
